// File: rtl/array_walk_pkg.sv
// Shared types and bound helpers for the array index walker.
// Optional bit-offset output is enabled by ARRAY_INDEX_WALKER_BITOFS_EN.
package array_walk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } walk_state_e;

    localparam int IDXW_DEF   = 8;
    localparam int SIZE_EXTRA = 1;
    localparam int SIZEW_DEF  = IDXW_DEF + SIZE_EXTRA;
    localparam int BOFS_PAD   = 16;
    // Helpers take bounds sign-extended to this width; IDXW must not exceed it.
    localparam int MAX_IDXW   = 31;

    function automatic logic [MAX_IDXW:0] dim_size(
        input logic signed [MAX_IDXW-1:0] left,
        input logic signed [MAX_IDXW-1:0] right
    );
        logic signed [MAX_IDXW:0] diff;
        diff = {left[MAX_IDXW-1], left} - {right[MAX_IDXW-1], right};
        if (diff[MAX_IDXW]) begin
            diff = -diff;
        end
        return $unsigned(diff) + {{MAX_IDXW{1'b0}}, 1'b1};
    endfunction

    function automatic logic signed [1:0] dim_step(
        input logic signed [MAX_IDXW-1:0] left,
        input logic signed [MAX_IDXW-1:0] right
    );
        return (left < right) ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/array_walk_dim.sv
// One odometer digit: holds its bounds, steps from left toward right and
// wraps back to left, passing the carry to the next-outer digit.
module array_walk_dim
    import array_walk_pkg::*;
#(
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            advance,
    input  logic            carry_in,
    input  logic [IDXW-1:0] left,
    input  logic [IDXW-1:0] right,
    output logic [IDXW-1:0] idx,
    output logic            at_right,
    output logic            carry_out
);

    logic [IDXW-1:0] left_q, left_d;
    logic [IDXW-1:0] right_q, right_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] step_ext;
    logic signed [1:0] step;

    assign at_right  = (idx_q == right_q);
    assign carry_out = carry_in & at_right;
    assign idx       = idx_q;

    always_comb begin
        step     = dim_step(MAX_IDXW'(signed'(left_q)), MAX_IDXW'(signed'(right_q)));
        step_ext = IDXW'(step);
        left_d   = left_q;
        right_d  = right_q;
        idx_d    = idx_q;
        if (load) begin
            left_d  = left;
            right_d = right;
            idx_d   = left;
        end else if (advance && carry_in) begin
            // A size-1 digit is always at_right, so it reloads left and never moves.
            idx_d = at_right ? left_q : idx_q + step_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_q  <= '0;
            right_q <= '0;
            idx_q   <= '0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/array_index_walker.sv
// Walks every element of a multidimensional array in declaration order.
// Define ARRAY_INDEX_WALKER_BITOFS_EN to add out_bitofs (first element latency 2).
module array_index_walker
    import array_walk_pkg::*;
#(
    parameter int NDIMS = 3,
    parameter int IDXW  = 8,
    parameter int ELEMW = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [NDIMS*IDXW-1:0]  cfg_left,
    input  logic [NDIMS*IDXW-1:0]  cfg_right,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NDIMS*IDXW-1:0]  out_idx,
    output logic [NDIMS*IDXW-1:0]  out_ord,
`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
    output logic [NDIMS*IDXW+15:0] out_bitofs,
`endif
    output logic                   out_last
);

    localparam int TOTW = NDIMS * IDXW;

    if (IDXW > MAX_IDXW || ELEMW < 1) begin : g_bad_cfg
        $error("array_index_walker: unsupported IDXW/ELEMW");
    end

    // Stream contract: an element transfers on a cycle with out_valid & out_ready
    // and abort low; out_* hold steady until then. A start transfers on
    // start_valid & start_ready.
    walk_state_e       state_q, state_d;
    logic [TOTW-1:0]   ord_q, ord_d;
    logic [NDIMS:0]    carry;
    logic [NDIMS-1:0]  at_right;
    logic              load;
    logic              advance;
    logic              emit;

    assign carry[NDIMS] = 1'b1;

    for (genvar d = 0; d < NDIMS; d++) begin : g_dim
        array_walk_dim #(
            .IDXW(IDXW)
        ) u_dim (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .advance  (advance),
            .carry_in (carry[d+1]),
            .left     (cfg_left[d*IDXW +: IDXW]),
            .right    (cfg_right[d*IDXW +: IDXW]),
            .idx      (out_idx[d*IDXW +: IDXW]),
            .at_right (at_right[d]),
            .carry_out(carry[d])
        );
    end

`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
    localparam int BOFW  = TOTW + BOFS_PAD;
    localparam int SIZEW = IDXW + SIZE_EXTRA;
    localparam int PRODW = TOTW + SIZEW;

    logic              prime_q, prime_d;
    logic [TOTW-1:0]   total_q, total_d;
    logic [BOFW-1:0]   bitofs_q, bitofs_d;
    logic [PRODW-1:0]  prod;

    assign emit = (state_q == RUN) && !prime_q;

    always_comb begin
        prod = {{(PRODW-1){1'b0}}, 1'b1};
        for (int d = 0; d < NDIMS; d++) begin
            prod = PRODW'(prod * PRODW'(dim_size(
                MAX_IDXW'(signed'(cfg_left[d*IDXW +: IDXW])),
                MAX_IDXW'(signed'(cfg_right[d*IDXW +: IDXW])))));
        end
        prime_d  = prime_q;
        total_d  = total_q;
        bitofs_d = bitofs_q;
        if (load) begin
            total_d = TOTW'(prod);
            prime_d = 1'b1;
        end else if (prime_q) begin
            // The all-left element sits at the top of the packed vector.
            prime_d  = 1'b0;
            bitofs_d = BOFW'((BOFW'(total_q) - BOFW'(1)) * BOFW'(ELEMW));
        end else if (advance) begin
            bitofs_d = bitofs_q - BOFW'(ELEMW);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_q  <= 1'b0;
            total_q  <= '0;
            bitofs_q <= '0;
        end else begin
            prime_q  <= prime_d;
            total_q  <= total_d;
            bitofs_q <= bitofs_d;
        end
    end

    assign out_bitofs = bitofs_q;
`else
    assign emit = (state_q == RUN);
`endif

    assign out_valid = emit;
    assign advance   = emit && out_ready && !abort;
    assign out_last  = emit && (&at_right);
    assign out_ord   = ord_q;

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // carry[0] out of the outermost digit marks the final transfer.
                if (abort || (advance && carry[0])) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ord_d = ord_q;
        if (load) begin
            ord_d = '0;
        end else if (advance) begin
            ord_d = ord_q + TOTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ord_q   <= '0;
        end else begin
            state_q <= state_d;
            ord_q   <= ord_d;
        end
    end

endmodule

// File: tb/tb_array_index_walker.sv
// Scoreboard bench for array_index_walker (NDIMS=3, IDXW=8, ELEMW=4); smaller
// walks use size-1 outer dimensions. Checks out_bitofs when ARRAY_INDEX_WALKER_BITOFS_EN is set.
module tb_array_index_walker;

    localparam int NDIMS = 3;
    localparam int IDXW  = 8;
    localparam int ELEMW = 4;
    localparam int TOTW  = NDIMS * IDXW;
    localparam int BOFW  = TOTW + 16;
    localparam int W     = 2 * TOTW + 1 + BOFW;
`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [TOTW-1:0] cfg_left = '0;
    logic [TOTW-1:0] cfg_right = '0;
    logic            abort = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TOTW-1:0] out_idx;
    logic [TOTW-1:0] out_ord;
    logic            out_last;
`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
    logic [BOFW-1:0] out_bitofs;
`endif

    logic [W-1:0] exp_q[$];
    int cfg_l[3];
    int cfg_r[3];
    int n_checks = 0;
    int n_errors = 0;

    array_index_walker #(
        .NDIMS(NDIMS),
        .IDXW (IDXW),
        .ELEMW(ELEMW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_ord    (out_ord),
`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
        .out_bitofs (out_bitofs),
`endif
        .out_last   (out_last)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TOTW-1:0] pack3(input int v0, input int v1, input int v2);
        logic [TOTW-1:0] p;
        p[7:0]   = 8'(v0);
        p[15:8]  = 8'(v1);
        p[23:16] = 8'(v2);
        return p;
    endfunction

    function automatic int step_of(input int l, input int r);
        return (l < r) ? 1 : -1;
    endfunction

    function automatic int size_of(input int l, input int r);
        return ((l > r) ? l - r : r - l) + 1;
    endfunction

    task automatic set_cfg(input int l0, input int r0, input int l1, input int r1,
                           input int l2, input int r2);
        cfg_l[0] = l0; cfg_r[0] = r0;
        cfg_l[1] = l1; cfg_r[1] = r1;
        cfg_l[2] = l2; cfg_r[2] = r2;
    endtask

    // Reference model: declaration-order enumeration, outermost slowest.
    task automatic push_model();
        int total;
        int ord;
        logic [W-1:0] e;
        total = size_of(cfg_l[0], cfg_r[0]) * size_of(cfg_l[1], cfg_r[1])
              * size_of(cfg_l[2], cfg_r[2]);
        ord = 0;
        for (int k0 = 0; k0 < size_of(cfg_l[0], cfg_r[0]); k0++) begin
            for (int k1 = 0; k1 < size_of(cfg_l[1], cfg_r[1]); k1++) begin
                for (int k2 = 0; k2 < size_of(cfg_l[2], cfg_r[2]); k2++) begin
                    e = '0;
                    e[TOTW-1:0] = pack3(cfg_l[0] + k0 * step_of(cfg_l[0], cfg_r[0]),
                                        cfg_l[1] + k1 * step_of(cfg_l[1], cfg_r[1]),
                                        cfg_l[2] + k2 * step_of(cfg_l[2], cfg_r[2]));
                    e[2*TOTW-1:TOTW] = TOTW'(ord);
                    e[2*TOTW]        = (ord == total - 1);
                    e[W-1:2*TOTW+1]  = BOFW'((total - 1 - ord) * ELEMW);
                    exp_q.push_back(e);
                    ord++;
                end
            end
        end
    endtask

    // mode: 0 ready held high, 1 ready toggles with start noise, 2 random ready.
    // stop_ord >= 0 ends the walk at that ordinal via abort or reset.
    task automatic run_walk(input int mode, input int stop_ord, input bit by_reset);
        int cyc;
        bit done;
        logic [W-1:0] e;
        push_model();
        @(posedge clk); #1;
        check("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        cfg_left    = pack3(cfg_l[0], cfg_l[1], cfg_l[2]);
        cfg_right   = pack3(cfg_r[0], cfg_r[1], cfg_r[2]);
        @(posedge clk); #1;
        start_valid = 1'b0;
        cfg_left    = TOTW'($urandom);
        cfg_right   = TOTW'($urandom);
        check("start_ready_busy", start_ready, 0);
        if (LAT == 2) begin
            check("prime_gap_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        check("first_valid", out_valid, 1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            case (mode)
                1:       out_ready = cyc[0];
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (mode == 1) begin
                start_valid = 1'b1;
                cfg_left    = TOTW'($urandom);
                cfg_right   = TOTW'($urandom);
            end
            abort = 1'b0;
            if (stop_ord >= 0 && out_valid && out_ord == TOTW'(stop_ord)) begin
                out_ready = 1'b1;
                if (by_reset) rst_n = 1'b0;
                else          abort = 1'b1;
            end
            @(negedge clk);
            if (!out_valid) begin
                check("no_bubble", out_valid, 1);
            end else if (exp_q.size() == 0) begin
                check("extra_element", out_valid, 0);
                done = 1'b1;
            end else begin
                e = exp_q[0];
                check("out_idx", out_idx, e[TOTW-1:0]);
                check("out_ord", out_ord, e[2*TOTW-1:TOTW]);
                check("out_last", out_last, e[2*TOTW]);
`ifdef ARRAY_INDEX_WALKER_BITOFS_EN
                check("out_bitofs", out_bitofs, e[W-1:2*TOTW+1]);
`endif
                if (abort || !rst_n) begin
                    @(posedge clk); #1;
                    check("stop_out_valid", out_valid, 0);
                    check("stop_start_ready", start_ready, 1);
                    if (!rst_n) begin
                        check("rst_out_ord", out_ord, 0);
                        check("rst_out_idx", out_idx, 0);
                        check("rst_out_last", out_last, 0);
                    end
                    abort = 1'b0;
                    rst_n = 1'b1;
                    exp_q.delete();
                    done = 1'b1;
                end else if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (e[2*TOTW]) begin
                        @(posedge clk); #1;
                        check("end_out_valid", out_valid, 0);
                        check("end_start_ready", start_ready, 1);
                        check("end_queue_empty", exp_q.size(), 0);
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) check("walk_timeout", 0, 1);
        start_valid = 1'b0;
        out_ready   = 1'b0;
        abort       = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // reset block
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_ord", out_ord, 0);
        rst_n = 1'b1;

        // abort while idle is ignored
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        check("idle_abort_ready", start_ready, 1);
        check("idle_abort_valid", out_valid, 0);
        abort = 1'b0;

        set_cfg(0, 0, 3, 0, 5, 1);
        run_walk(0, -1, 1'b0);
        set_cfg(0, 0, 0, 0, 2, 7);
        run_walk(0, -1, 1'b0);
        set_cfg(0, 0, 0, 3, 4, 4);
        run_walk(0, -1, 1'b0);
        set_cfg(0, 0, 3, 0, 5, 1);
        run_walk(1, -1, 1'b0);
        run_walk(0, 7, 1'b0);
        run_walk(2, -1, 1'b0);
        run_walk(0, 7, 1'b1);
        run_walk(0, -1, 1'b0);
        set_cfg(0, 0, 0, 0, 1, 0);
        run_walk(0, -1, 1'b0);
        set_cfg(-2, 1, 1, -1, 0, 0);
        run_walk(2, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
